// File: rtl/dnn_compute_sequencer_if.sv
// ---------------------------------------------------------------------------
// dnn_compute_sequencer_if
// Bundles the control/status signals between the command controller / array
// and the DNN compute sequencer.
//   master : command side. Drives the load toggles and addr_clr, observes status.
//   slave  : sequencer. Consumes the toggles, drives strobes, address and status.
// Signals:
//   isNewDin, isNewWtin : level toggles, one change per completed buffer load
//   addr_clr            : one-cycle pulse, zeroes write address and overrun
//   wt_load, arr_start  : one-cycle strobes to the systolic array
//   out_we, out_addr    : output buffer write port
//   busy, done_toggle   : sequencer activity / per-write completion toggle
//   overrun             : sticky, input arrived while a previous one was pending
//   perf_count          : completed-compute counter (zero unless enabled)
// ---------------------------------------------------------------------------
interface dnn_compute_sequencer_if #(
    parameter int M  = 16,
    parameter int AW = (M > 1) ? $clog2(M) : 1
);
    logic          isNewDin;
    logic          isNewWtin;
    logic          addr_clr;
    logic          wt_load;
    logic          arr_start;
    logic          out_we;
    logic [AW-1:0] out_addr;
    logic          busy;
    logic          done_toggle;
    logic          overrun;
    logic [15:0]   perf_count;

    modport master (
        output isNewDin, isNewWtin, addr_clr,
        input  wt_load, arr_start, out_we, out_addr, busy, done_toggle, overrun, perf_count
    );

    modport slave (
        input  isNewDin, isNewWtin, addr_clr,
        output wt_load, arr_start, out_we, out_addr, busy, done_toggle, overrun, perf_count
    );
endinterface

// File: rtl/dnn_compute_sequencer.sv
// ---------------------------------------------------------------------------
// dnn_compute_sequencer
// Schedules the DNN compute datapath once the UART side has loaded the weight
// and input buffers. Each weight toggle produces one wt_load strobe; each input
// toggle (once weights are valid) produces one arr_start strobe followed,
// PIPE_LAT cycles later, by an output buffer write at an auto-incrementing,
// wrapping address.
//
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : dnn_compute_sequencer_if.slave (toggles in, strobes/status out)
//
// Parameters:
//   M        : output buffer depth, out_addr is $clog2(M) bits
//   PIPE_LAT : arr_start to result-valid latency, 1..255
//
// Build option: define SEQ_PERF_CNT_EN to enable the saturating perf_count
// counter; otherwise perf_count is a constant zero.
// ---------------------------------------------------------------------------
module dnn_compute_sequencer #(
    parameter int M        = 16,
    parameter int PIPE_LAT = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    dnn_compute_sequencer_if.slave  bus
);
    localparam int AW = (M > 1) ? $clog2(M) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_WT = 3'd1;
    localparam logic [2:0] S_START   = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_state_next;
    logic          r_primed;
    logic          r_prev_din;
    logic          r_prev_wt;
    logic          r_wt_pend;
    logic          r_in_pend;
    logic          r_wt_valid;
    logic [7:0]    r_drain_cnt;
    logic          r_wt_load;
    logic          r_arr_start;
    logic          r_out_we;
    logic          r_busy;
    logic [AW-1:0] r_out_addr;
    logic          r_done_toggle;
    logic          r_overrun;
    logic          w_wt_evt;
    logic          w_in_evt;

    // The first clock after reset only samples the toggle levels, so whatever
    // level the loader left behind does not masquerade as a fresh event.
    assign w_wt_evt = r_primed & (bus.isNewWtin ^ r_prev_wt);
    assign w_in_evt = r_primed & (bus.isNewDin  ^ r_prev_din);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_wt_pend)
                    w_state_next = S_LOAD_WT;
                else if (r_in_pend && r_wt_valid)
                    w_state_next = S_START;
            end
            S_LOAD_WT: w_state_next = S_IDLE;
            S_START:   w_state_next = (PIPE_LAT == 1) ? S_WRITE : S_DRAIN;
            // Counter is decremented in this cycle; leaving when it would reach
            // 1 places WRITE exactly PIPE_LAT cycles after START.
            S_DRAIN:   if (r_drain_cnt <= 8'd2) w_state_next = S_WRITE;
            S_WRITE:   w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_primed    <= 1'b0;
            r_prev_din  <= 1'b0;
            r_prev_wt   <= 1'b0;
            r_wt_pend   <= 1'b0;
            r_in_pend   <= 1'b0;
            r_wt_valid  <= 1'b0;
            r_drain_cnt <= 8'd0;
            r_wt_load   <= 1'b0;
            r_arr_start <= 1'b0;
            r_out_we    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_primed   <= 1'b1;
            r_prev_din <= bus.isNewDin;
            r_prev_wt  <= bus.isNewWtin;

            // A new event arriving in the consuming cycle must survive.
            if (w_wt_evt)
                r_wt_pend <= 1'b1;
            else if (r_state == S_LOAD_WT)
                r_wt_pend <= 1'b0;

            if (w_in_evt)
                r_in_pend <= 1'b1;
            else if (r_state == S_START)
                r_in_pend <= 1'b0;

            if (r_state == S_LOAD_WT)
                r_wt_valid <= 1'b1;

            if (r_state == S_START)
                r_drain_cnt <= 8'(PIPE_LAT);
            else if (r_state == S_DRAIN)
                r_drain_cnt <= r_drain_cnt - 8'd1;

            // Strobes are decoded from the next state so they are true flops
            // aligned with the state they belong to.
            r_wt_load   <= (w_state_next == S_LOAD_WT);
            r_arr_start <= (w_state_next == S_START);
            r_out_we    <= (w_state_next == S_WRITE);
            r_busy      <= (w_state_next != S_IDLE);
        end
    end

    // Write address, completion toggle and overrun flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_addr    <= '0;
            r_done_toggle <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            // Clear wins over the post-write increment; the write itself has
            // already used the old address during WRITE.
            if (bus.addr_clr)
                r_out_addr <= '0;
            else if (r_state == S_WRITE)
                r_out_addr <= (r_out_addr == AW'(M - 1)) ? '0 : r_out_addr + 1'b1;

            if (r_state == S_WRITE)
                r_done_toggle <= ~r_done_toggle;

            if (bus.addr_clr)
                r_overrun <= 1'b0;
            else if (w_in_evt && r_in_pend && (r_state != S_START))
                r_overrun <= 1'b1;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] r_perf_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_perf_count <= 16'h0000;
        else if ((r_state == S_WRITE) && (r_perf_count != 16'hFFFF))
            r_perf_count <= r_perf_count + 16'd1;
    end

    assign bus.perf_count = r_perf_count;
`else
    assign bus.perf_count = 16'h0000;
`endif

    assign bus.wt_load     = r_wt_load;
    assign bus.arr_start   = r_arr_start;
    assign bus.out_we      = r_out_we;
    assign bus.out_addr    = r_out_addr;
    assign bus.busy        = r_busy;
    assign bus.done_toggle = r_done_toggle;
    assign bus.overrun     = r_overrun;
endmodule

// File: tb/tb_dnn_compute_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dnn_compute_sequencer
// Directed scenarios plus randomized compute jobs. A negedge monitor keeps the
// reference view: every arr_start must be followed by exactly one out_we
// PIPE_LAT cycles later, writes must land on a modulo-M address sequence
// (restarted by reset or addr_clr), and wt_load must never appear while a
// compute is in flight. Scenario code predicts event counts from the toggles
// it issued.
// ---------------------------------------------------------------------------
module tb_dnn_compute_sequencer;
    localparam int M        = 16;
    localparam int PIPE_LAT = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    dnn_compute_sequencer_if #(.M(M)) bus();

    dnn_compute_sequencer #(.M(M), .PIPE_LAT(PIPE_LAT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok %s = %0d", tag, got);
        end
    endtask

    // ---------------- monitor / reference ----------------
    int   cyc = 0;
    int   n_wl = 0, n_as = 0, n_we = 0, n_done = 0;
    int   exp_addr = 0;
    int   last_we_cyc = 0, last_wl_cyc = 0;
    int   q_start[$];
    bit   in_comp = 0;
    logic prev_done = 1'b0;

    always @(negedge clock) begin
        cyc++;
        if (!reset) begin
            q_start.delete();
            in_comp   = 0;
            exp_addr  = 0;
            prev_done = 1'b0;
        end else begin
            if (bus.wt_load) begin
                n_wl++;
                last_wl_cyc = cyc;
                check("wt_load_outside_compute", 32'(in_comp), 32'd0);
            end
            if (bus.arr_start) begin
                n_as++;
                q_start.push_back(cyc);
                in_comp = 1;
            end
            if (bus.out_we) begin
                n_we++;
                last_we_cyc = cyc;
                if (q_start.size() == 0)
                    check("we_without_start", 32'd1, 32'd0);
                else
                    check("we_latency", 32'(cyc - q_start.pop_front()), 32'(PIPE_LAT));
                check("we_addr", 32'(bus.out_addr), 32'(exp_addr));
                exp_addr = (exp_addr + 1) % M;
                in_comp  = 0;
            end
            if (bus.addr_clr)
                exp_addr = 0;
            if (bus.done_toggle !== prev_done) begin
                n_done++;
                prev_done = bus.done_toggle;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
    endtask

    task automatic wait_we(input int target, input int budget);
        int k = 0;
        while (n_we < target && k < budget) begin
            tick();
            k++;
        end
        if (n_we < target) check("wait_out_we", 32'(n_we), 32'(target));
    endtask

    task automatic wait_as(input int target, input int budget);
        int k = 0;
        while (n_as < target && k < budget) begin
            tick();
            k++;
        end
        if (n_as < target) check("wait_arr_start", 32'(n_as), 32'(target));
    endtask

    int b_wl, b_as, b_we, b_done, wt_toggles, jobs;

    initial begin
        bus.isNewWtin = 1'b1;
        bus.isNewDin  = 1'b1;
        bus.addr_clr  = 1'b0;

        // 1: reset state, toggle levels present at release create no events
        reset = 1'b0;
        tick(2);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_wt_load", 32'(bus.wt_load), 32'd0);
        check("rst_arr_start", 32'(bus.arr_start), 32'd0);
        check("rst_out_we", 32'(bus.out_we), 32'd0);
        check("rst_out_addr", 32'(bus.out_addr), 32'd0);
        check("rst_done", 32'(bus.done_toggle), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        check("rst_perf", 32'(bus.perf_count), 32'd0);
        reset = 1'b1;
        tick(20);
        check("release_wt_load_cnt", 32'(n_wl), 32'd0);
        check("release_arr_start_cnt", 32'(n_as), 32'd0);
        check("release_busy", 32'(bus.busy), 32'd0);

        // 2: weights, then input 3 cycles later
        b_wl = n_wl; b_as = n_as; b_we = n_we;
        bus.isNewWtin = ~bus.isNewWtin;
        tick(3);
        bus.isNewDin = ~bus.isNewDin;
        wait_we(b_we + 1, 50);
        tick(3);
        check("basic_wt_load_cnt", 32'(n_wl - b_wl), 32'd1);
        check("basic_arr_start_cnt", 32'(n_as - b_as), 32'd1);
        check("basic_done", 32'(bus.done_toggle), 32'd1);
        check("basic_addr_after", 32'(bus.out_addr), 32'd1);
        check("basic_busy_after", 32'(bus.busy), 32'd0);

        // 3: input without weights is held, then served after weights arrive
        do_reset();
        tick(2);
        b_wl = n_wl; b_as = n_as; b_we = n_we;
        bus.isNewDin = ~bus.isNewDin;
        tick(20);
        check("nowt_arr_start_cnt", 32'(n_as - b_as), 32'd0);
        check("nowt_busy", 32'(bus.busy), 32'd0);
        bus.isNewWtin = ~bus.isNewWtin;
        wait_we(b_we + 1, 50);
        tick(3);
        check("held_wt_load_cnt", 32'(n_wl - b_wl), 32'd1);
        check("held_arr_start_cnt", 32'(n_as - b_as), 32'd1);

        // 4: 17 back-to-back jobs wrap the address
        do_reset();
        tick(2);
        bus.isNewWtin = ~bus.isNewWtin;
        tick(5);
        b_done = n_done; b_we = n_we;
        for (int j = 0; j < 17; j++) begin
            bus.isNewDin = ~bus.isNewDin;
            wait_we(b_we + j + 1, 50);
        end
        tick(4);
        check("wrap_done_flips", 32'(n_done - b_done), 32'd17);
        check("wrap_addr_after", 32'(bus.out_addr), 32'd1);
`ifdef SEQ_PERF_CNT_EN
        check("wrap_perf_count", 32'(bus.perf_count), 32'd17);
`else
        check("wrap_perf_count", 32'(bus.perf_count), 32'd0);
`endif

        // 5: two input toggles during one DRAIN -> overrun, one extra compute
        b_as = n_as; b_we = n_we;
        bus.isNewDin = ~bus.isNewDin;
        wait_as(b_as + 1, 50);
        bus.isNewDin = ~bus.isNewDin;
        tick();
        bus.isNewDin = ~bus.isNewDin;
        wait_we(b_we + 2, 100);
        tick(15);
        check("ovr_flag", 32'(bus.overrun), 32'd1);
        check("ovr_arr_start_cnt", 32'(n_as - b_as), 32'd2);
        bus.addr_clr = 1'b1;
        tick();
        bus.addr_clr = 1'b0;
        tick();
        check("clr_overrun", 32'(bus.overrun), 32'd0);
        check("clr_addr", 32'(bus.out_addr), 32'd0);

        // 6a: weight toggle during DRAIN is deferred until after the write
        b_wl = n_wl; b_as = n_as; b_we = n_we;
        bus.isNewDin = ~bus.isNewDin;
        wait_as(b_as + 1, 50);
        bus.isNewWtin = ~bus.isNewWtin;
        wait_we(b_we + 1, 50);
        tick(6);
        check("defer_wt_load_cnt", 32'(n_wl - b_wl), 32'd1);
        check("defer_wt_load_gap", 32'(last_wl_cyc - last_we_cyc), 32'd2);

        // 6b: reset asserted mid-DRAIN
        b_as = n_as;
        bus.isNewDin = ~bus.isNewDin;
        wait_as(b_as + 1, 50);
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_out_we", 32'(bus.out_we), 32'd0);
        tick(2);
        reset = 1'b1;
        b_we = n_we;
        tick(20);
        check("midrst_no_write", 32'(n_we - b_we), 32'd0);

        // 7: randomized jobs, optional weight reloads before or mid-compute
        do_reset();
        tick(2);
        bus.isNewWtin = ~bus.isNewWtin;
        tick(4);
        b_wl = n_wl; b_as = n_as; b_we = n_we; b_done = n_done;
        wt_toggles = 0;
        jobs = 20;
        for (int j = 0; j < jobs; j++) begin
            if ($urandom_range(0, 1) == 1) begin
                bus.isNewWtin = ~bus.isNewWtin;
                wt_toggles++;
                tick($urandom_range(0, 3));
            end
            bus.isNewDin = ~bus.isNewDin;
            if ($urandom_range(0, 2) == 0) begin
                wait_as(b_as + j + 1, 50);
                bus.isNewWtin = ~bus.isNewWtin;
                wt_toggles++;
            end
            wait_we(b_we + j + 1, 60);
            tick($urandom_range(3, 6));
        end
        tick(10);
        check("rand_wt_load_cnt", 32'(n_wl - b_wl), 32'(wt_toggles));
        check("rand_arr_start_cnt", 32'(n_as - b_as), 32'(jobs));
        check("rand_done_flips", 32'(n_done - b_done), 32'(jobs));
        check("rand_addr_after", 32'(bus.out_addr), 32'(jobs % M));
        check("rand_overrun", 32'(bus.overrun), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
